// File: rtl/stack_fault_unit.sv
// Stack fault unit: turns one-cycle stack overflow/underflow flags into a held
// trap request with captured context, a pipeline stall and saturating stats.
module stack_fault_unit #(
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              overflow,
    input  logic              underflow,
    input  logic [DATA_W-1:0] pc_val,
    input  logic [DATA_W-1:0] sp_val,
    input  logic              fault_ack,
    input  logic              clear_stats,
    output logic              stall,
    output logic              trap_valid,
    output logic [1:0]        trap_cause,
    output logic [DATA_W-1:0] fault_pc,
    output logic [DATA_W-1:0] fault_sp,
    output logic [CNT_W-1:0]  ovf_count,
    output logic [CNT_W-1:0]  unf_count,
    output logic              lost_fault
);

    typedef enum logic [1:0] {
        IDLE,
        TRAP,
        DRAIN
    } state_t;

    localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DC_W-1:0] DC_LOAD = DC_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          state;
    state_t          state_nx;
    logic [DC_W-1:0] dcnt;
    logic [DC_W-1:0] dcnt_nx;

    logic fault;
    logic accept;
    logic lost;

    assign fault  = overflow | underflow;
    assign accept = (state == IDLE) && fault;
    assign lost   = (state != IDLE) && fault;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        unique case (state)
            IDLE: begin
                if (fault) begin
                    state_nx = TRAP;
                end
            end
            TRAP: begin
                if (fault_ack) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = DRAIN;
                        dcnt_nx  = DC_LOAD;
                    end
                end
            end
            DRAIN: begin
                dcnt_nx = dcnt - DC_W'(1);
                if (dcnt == DC_W'(1)) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                dcnt_nx  = '0;
            end
        endcase
    end

    // stall/trap_valid are registered from the next state so they track it exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dcnt       <= '0;
            stall      <= 1'b0;
            trap_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            dcnt       <= dcnt_nx;
            stall      <= (state_nx != IDLE);
            trap_valid <= (state_nx == TRAP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_cause <= '0;
            fault_pc   <= '0;
            fault_sp   <= '0;
        end else if (accept) begin
            trap_cause <= {underflow, overflow};
            fault_pc   <= pc_val;
            fault_sp   <= sp_val;
        end
    end

    // An accepted fault beats a same-edge clear for its own counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count  <= '0;
            unf_count  <= '0;
            lost_fault <= 1'b0;
        end else begin
            if (accept && overflow) begin
                ovf_count <= clear_stats ? CNT_W'(1) : sat_inc(ovf_count);
            end else if (clear_stats) begin
                ovf_count <= '0;
            end

            if (accept && underflow) begin
                unf_count <= clear_stats ? CNT_W'(1) : sat_inc(unf_count);
            end else if (clear_stats) begin
                unf_count <= '0;
            end

            if (lost) begin
                lost_fault <= 1'b1;
            end else if (clear_stats) begin
                lost_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stack_fault_unit.sv
// Bench for stack_fault_unit: two builds (default, and CNT_W=2/DRAIN_CYCLES=0)
// share stimulus and are compared every cycle against a behavioural model.
module tb_stack_fault_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        overflow = 1'b0;
    logic        underflow = 1'b0;
    logic [31:0] pc_val = '0;
    logic [31:0] sp_val = '0;
    logic        fault_ack = 1'b0;
    logic        clear_stats = 1'b0;

    logic        a_stall, a_tv, a_lost;
    logic [1:0]  a_cause;
    logic [31:0] a_pc, a_sp;
    logic [7:0]  a_ovf, a_unf;

    logic        b_stall, b_tv, b_lost;
    logic [1:0]  b_cause;
    logic [31:0] b_pc, b_sp;
    logic [1:0]  b_ovf, b_unf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stack_fault_unit #(.DATA_W(32), .CNT_W(8), .DRAIN_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .overflow(overflow), .underflow(underflow),
        .pc_val(pc_val), .sp_val(sp_val), .fault_ack(fault_ack),
        .clear_stats(clear_stats), .stall(a_stall), .trap_valid(a_tv),
        .trap_cause(a_cause), .fault_pc(a_pc), .fault_sp(a_sp),
        .ovf_count(a_ovf), .unf_count(a_unf), .lost_fault(a_lost)
    );

    stack_fault_unit #(.DATA_W(32), .CNT_W(2), .DRAIN_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .overflow(overflow), .underflow(underflow),
        .pc_val(pc_val), .sp_val(sp_val), .fault_ack(fault_ack),
        .clear_stats(clear_stats), .stall(b_stall), .trap_valid(b_tv),
        .trap_cause(b_cause), .fault_pc(b_pc), .fault_sp(b_sp),
        .ovf_count(b_ovf), .unf_count(b_unf), .lost_fault(b_lost)
    );

    // Model: a pending trap flag plus "stall cycles left" after the ack
    typedef struct {
        bit          pend;
        int          left;
        bit [1:0]    cause;
        logic [31:0] pc;
        logic [31:0] sp;
        int          ovf;
        int          unf;
        bit          lost;
    } mdl_t;

    mdl_t m[2];
    int   m_drain[2] = '{2, 0};
    int   m_max[2]   = '{255, 3};

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.pend = 0; r.left = 0; r.cause = 0;
        r.pc = 0; r.sp = 0; r.ovf = 0; r.unf = 0; r.lost = 0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        m[0] = mdl_reset();
        m[1] = mdl_reset();
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    m[i] = mdl_reset();
                end else begin
                    bit flt;
                    bit idle;
                    flt  = overflow | underflow;
                    idle = !m[i].pend && (m[i].left == 0);
                    if (idle && flt) begin
                        m[i].pend  = 1;
                        m[i].cause = {underflow, overflow};
                        m[i].pc    = pc_val;
                        m[i].sp    = sp_val;
                        if (overflow)
                            m[i].ovf = clear_stats ? 1
                                     : (m[i].ovf < m_max[i] ? m[i].ovf + 1 : m[i].ovf);
                        else if (clear_stats)
                            m[i].ovf = 0;
                        if (underflow)
                            m[i].unf = clear_stats ? 1
                                     : (m[i].unf < m_max[i] ? m[i].unf + 1 : m[i].unf);
                        else if (clear_stats)
                            m[i].unf = 0;
                    end else begin
                        if (clear_stats) begin
                            m[i].ovf = 0;
                            m[i].unf = 0;
                        end
                        if (m[i].pend && fault_ack) begin
                            m[i].pend = 0;
                            m[i].left = m_drain[i];
                        end else if (m[i].left > 0) begin
                            m[i].left--;
                        end
                    end
                    if (!idle && flt) m[i].lost = 1;
                    else if (clear_stats) m[i].lost = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("a.stall", 64'(a_stall), 64'(m[0].pend || m[0].left > 0));
            chk("a.trap_valid", 64'(a_tv), 64'(m[0].pend));
            chk("a.cause", 64'(a_cause), 64'(m[0].cause));
            chk("a.pc", 64'(a_pc), 64'(m[0].pc));
            chk("a.sp", 64'(a_sp), 64'(m[0].sp));
            chk("a.ovf", 64'(a_ovf), 64'(m[0].ovf));
            chk("a.unf", 64'(a_unf), 64'(m[0].unf));
            chk("a.lost", 64'(a_lost), 64'(m[0].lost));
            chk("b.stall", 64'(b_stall), 64'(m[1].pend || m[1].left > 0));
            chk("b.trap_valid", 64'(b_tv), 64'(m[1].pend));
            chk("b.cause", 64'(b_cause), 64'(m[1].cause));
            chk("b.pc", 64'(b_pc), 64'(m[1].pc));
            chk("b.sp", 64'(b_sp), 64'(m[1].sp));
            chk("b.ovf", 64'(b_ovf), 64'(m[1].ovf));
            chk("b.unf", 64'(b_unf), 64'(m[1].unf));
            chk("b.lost", 64'(b_lost), 64'(m[1].lost));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".stall"}, 64'(a_stall), 0);
        chk({nm, ".trap_valid"}, 64'(a_tv), 0);
        chk({nm, ".cause"}, 64'(a_cause), 0);
        chk({nm, ".pc"}, 64'(a_pc), 0);
        chk({nm, ".sp"}, 64'(a_sp), 0);
        chk({nm, ".ovf"}, 64'(a_ovf), 0);
        chk({nm, ".unf"}, 64'(a_unf), 0);
        chk({nm, ".lost"}, 64'(a_lost), 0);
    endtask

    int sat_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        tick(2);
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Overflow trap, ack three cycles later, two drain cycles
        pc_val = 32'h40; sp_val = 32'hFFFF_FFF4; overflow = 1'b1;
        tick();
        overflow = 1'b0;
        chk("ovf.trap_valid", 64'(a_tv), 1);
        chk("ovf.stall", 64'(a_stall), 1);
        chk("ovf.cause", 64'(a_cause), 64'h1);
        chk("ovf.pc", 64'(a_pc), 64'h40);
        chk("ovf.sp", 64'(a_sp), 64'hFFFF_FFF4);
        chk("ovf.count", 64'(a_ovf), 1);
        tick(2);
        fault_ack = 1'b1;
        tick();
        fault_ack = 1'b0;
        chk("ack.trap_valid", 64'(a_tv), 0);
        chk("ack.stall_d1", 64'(a_stall), 1);
        chk("ack.b_stall_nodrain", 64'(b_stall), 0);
        tick();
        chk("ack.stall_d2", 64'(a_stall), 1);
        tick();
        chk("ack.stall_done", 64'(a_stall), 0);

        // Both flags with clear on the same edge: faults win both counters
        pc_val = 32'h80; sp_val = 32'h100;
        overflow = 1'b1; underflow = 1'b1; clear_stats = 1'b1;
        tick();
        overflow = 1'b0; underflow = 1'b0; clear_stats = 1'b0;
        chk("both.cause", 64'(a_cause), 64'h3);
        chk("both.ovf", 64'(a_ovf), 1);
        chk("both.unf", 64'(a_unf), 1);

        // Underflow while waiting for ack is lost, not captured
        pc_val = 32'h999; sp_val = 32'h555; underflow = 1'b1;
        tick();
        underflow = 1'b0;
        chk("lost.unf", 64'(a_unf), 1);
        chk("lost.pc", 64'(a_pc), 64'h80);
        chk("lost.sp", 64'(a_sp), 64'h100);
        chk("lost.flag", 64'(a_lost), 1);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("clr.lost", 64'(a_lost), 0);
        chk("clr.ovf", 64'(a_ovf), 0);
        chk("clr.unf", 64'(a_unf), 0);
        chk("clr.trap_valid", 64'(a_tv), 1);
        chk("clr.cause", 64'(a_cause), 64'h3);
        clear_stats = 1'b1; underflow = 1'b1;
        tick();
        clear_stats = 1'b0; underflow = 1'b0;
        chk("clr_lost.same_edge", 64'(a_lost), 1);
        fault_ack = 1'b1;
        tick();
        fault_ack = 1'b0;
        tick(3);

        // Saturation on the 2-bit counter build
        for (int i = 0; i < 5; i++) begin
            pc_val = 32'h1000 + 32'(i); overflow = 1'b1;
            tick();
            overflow = 1'b0;
            chk($sformatf("sat.b_ovf[%0d]", i), 64'(b_ovf), 64'(sat_exp[i]));
            fault_ack = 1'b1;
            tick();
            fault_ack = 1'b0;
            tick(3);
        end
        chk("sat.a_ovf", 64'(a_ovf), 5);

        // Async reset during DRAIN
        overflow = 1'b1;
        tick();
        overflow = 1'b0; fault_ack = 1'b1;
        tick();
        fault_ack = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_drain");
        tick();
        rst = 1'b0;
        tick();

        // Async reset during TRAP, then a fault on the first edge after release
        pc_val = 32'h300; overflow = 1'b1;
        tick();
        overflow = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_trap");
        tick();
        rst = 1'b0;
        pc_val = 32'h200; sp_val = 32'h1234; overflow = 1'b1;
        tick();
        overflow = 1'b0;
        chk("post_rst.trap_valid", 64'(a_tv), 1);
        chk("post_rst.pc", 64'(a_pc), 64'h200);
        chk("post_rst.sp", 64'(a_sp), 64'h1234);
        chk("post_rst.ovf", 64'(a_ovf), 1);
        fault_ack = 1'b1;
        tick();
        fault_ack = 1'b0;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
